// File: rtl/pll_phase_pkg.sv
// Shared types and defaults for the PLL phase-shift responder.
package pll_phase_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_LATENCY      = 2'd1,
    ST_DONE_LOW     = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_t;

  localparam int STEP_LATENCY_DEF    = 2;
  localparam int DONE_LOW_CYCLES_DEF = 2;
  localparam int PHASE_STEPS_DEF     = 64;

  localparam int PHASE_W = 8;
  // Latency/width counter; wide enough for any sensible latency setting.
  localparam int CNT_W   = 16;

  typedef logic [PHASE_W-1:0] phase_t;

endpackage

// File: rtl/pll_phase_shift_responder_if.sv
// Phase-shift handshake between a driver (master) and the responder (slave).
// Signal prefixes are relative to the responder.
interface pll_phase_shift_responder_if;
  import pll_phase_pkg::*;

  logic       i_phasestep;
  logic       i_updown;
  logic       i_pll_select;
  logic       o_phasedone;
  phase_t     o_phase;
  logic [7:0] o_step_count;
  logic       o_busy;
  logic       o_protocol_err;

  modport master (
    output i_phasestep, i_updown, i_pll_select,
    input  o_phasedone, o_phase, o_step_count, o_busy, o_protocol_err
  );

  modport slave (
    input  i_phasestep, i_updown, i_pll_select,
    output o_phasedone, o_phase, o_step_count, o_busy, o_protocol_err
  );

endinterface

// File: rtl/pll_phase_accumulator.sv
// Modulo up/down phase position counter. Compare is done at full 8-bit width
// so a modulus of 256 wraps without overflow.
module pll_phase_accumulator
  import pll_phase_pkg::*;
#(
  parameter int PHASE_STEPS = PHASE_STEPS_DEF
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_en,
  input  logic   i_up,
  output phase_t o_phase
);

  localparam phase_t PHASE_MAX = phase_t'(PHASE_STEPS - 1);

  // Advance or retard one step per enable, wrapping at the modulus.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_phase <= '0;
    end else if (i_en) begin
      if (i_up) begin
        o_phase <= (o_phase == PHASE_MAX) ? '0 : o_phase + 8'd1;
      end else begin
        o_phase <= (o_phase == '0) ? PHASE_MAX : o_phase - 8'd1;
      end
    end
  end

endmodule

// File: rtl/pll_phase_shift_responder.sv
// Behavioural stand-in for one PLL channel's dynamic phase-shift port.
//
//   state           | meaning
//   ----------------+-----------------------------------------------------
//   ST_IDLE         | waiting for phasestep addressed to this channel
//   ST_LATENCY      | request accepted; first cycle checks minimum hold
//   ST_DONE_LOW     | phasedone driven low for the configured width
//   ST_WAIT_RELEASE | step done; wait for phasestep to drop before rearming
module pll_phase_shift_responder
  import pll_phase_pkg::*;
#(
  parameter int PLL_NUM         = 0,
  parameter int STEP_LATENCY    = STEP_LATENCY_DEF,
  parameter int DONE_LOW_CYCLES = DONE_LOW_CYCLES_DEF,
  parameter int PHASE_STEPS     = PHASE_STEPS_DEF
) (
  input logic                         i_clk,
  input logic                         i_rst_n,
  pll_phase_shift_responder_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'(STEP_LATENCY - 1);
  localparam logic [CNT_W-1:0] DONE_LOAD = CNT_W'(DONE_LOW_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             dir_up;
  logic             sel_match;
  logic             step_en;

  assign sel_match = (32'(bus.i_pll_select) == PLL_NUM);

  // The first LATENCY cycle always has cnt == LAT_LOAD != 0 (latency >= 2),
  // so the hold check and the step commit can never coincide.
  assign step_en = (state == ST_LATENCY) && (cnt == '0);

  pll_phase_accumulator #(
    .PHASE_STEPS (PHASE_STEPS)
  ) u_accum (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (step_en),
    .i_up    (dir_up),
    .o_phase (bus.o_phase)
  );

  // Handshake sequencer with latency/width timer, step counter and error flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state              <= ST_IDLE;
      cnt                <= '0;
      dir_up             <= 1'b0;
      bus.o_phasedone    <= 1'b1;
      bus.o_step_count   <= '0;
      bus.o_busy         <= 1'b0;
      bus.o_protocol_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_phasestep && sel_match) begin
            dir_up     <= bus.i_updown;
            cnt        <= LAT_LOAD;
            state      <= ST_LATENCY;
            bus.o_busy <= 1'b1;
          end
        end
        ST_LATENCY: begin
          if ((cnt == LAT_LOAD) && !bus.i_phasestep) begin
            bus.o_protocol_err <= 1'b1;
            cnt                <= '0;
            state              <= ST_IDLE;
            bus.o_busy         <= 1'b0;
          end else if (cnt == '0) begin
            bus.o_phasedone  <= 1'b0;
            bus.o_step_count <= (bus.o_step_count == 8'hFF) ? 8'hFF
                                                            : bus.o_step_count + 8'd1;
            cnt              <= DONE_LOAD;
            state            <= ST_DONE_LOW;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE_LOW: begin
          if (cnt == '0) begin
            bus.o_phasedone <= 1'b1;
            state           <= ST_WAIT_RELEASE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WAIT_RELEASE: begin
          if (!bus.i_phasestep) begin
            state      <= ST_IDLE;
            bus.o_busy <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          bus.o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
